// File: rtl/timer_tick_ctrl.sv
// Tick/control sequencer for the LSD of a cascaded countdown-digit chain.
// Optional feature: define TIMER_AUTORELOAD_EN to auto-reload after RELOAD_HOLD cycles in EXPIRED.
module timer_tick_ctrl #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned RELOAD_HOLD = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic startBtn,
    input  logic pauseBtn,
    input  logic timeUp,
    output logic reconfig,
    output logic decLSD,
    output logic running,
    output logic expired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    localparam logic [CNT_W-1:0] TERM       = CNT_W'(TICK_DIV - 1);
    localparam int unsigned      SETTLE_CYC = NUM_DIGITS + 1;
    localparam int unsigned      SET_W      = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_CYC - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               start_q, pause_q;
    logic               start_edge, pause_edge, at_term;

`ifdef TIMER_AUTORELOAD_EN
    localparam int unsigned       HOLD_W    = $clog2(RELOAD_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RELOAD_HOLD - 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    assign start_edge = startBtn & ~start_q;
    assign pause_edge = pauseBtn & ~pause_q;
    assign at_term    = (presc_q == TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            settle_q <= '0;
            start_q  <= 1'b0;
            pause_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            settle_q <= settle_d;
            start_q  <= startBtn;
            pause_q  <= pauseBtn;
        end
    end

`ifdef TIMER_AUTORELOAD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_edge) state_d = S_LOAD;
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: if (settle_q == SET_LAST) state_d = S_RUN;
            S_RUN: begin
                if (timeUp)          state_d = S_EXPIRED;
                else if (start_edge) state_d = S_LOAD;
                else if (pause_edge) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (timeUp)          state_d = S_EXPIRED;
                else if (start_edge) state_d = S_LOAD;
                else if (pause_edge) state_d = S_RUN;
            end
            S_EXPIRED: begin
`ifdef TIMER_AUTORELOAD_EN
                if (start_edge || (hold_q == HOLD_LAST)) state_d = S_LOAD;
`else
                if (start_edge) state_d = S_LOAD;
`endif
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d  = '0;
        settle_d = '0;
        if ((state_q == S_SETTLE) && (settle_q != SET_LAST)) begin
            settle_d = settle_q + 1'b1;
        end
        case (state_q)
            S_RUN: begin
                if (timeUp || start_edge) begin
                    presc_d = '0;
                end else if (pause_edge) begin
                    // A pause landing on the terminal count keeps the tick just issued and
                    // parks at 0, so resuming cannot re-issue the same decrement.
                    presc_d = at_term ? '0 : presc_q;
                end else begin
                    presc_d = at_term ? '0 : presc_q + 1'b1;
                end
            end
            S_PAUSE: begin
                presc_d = (timeUp || start_edge) ? '0 : presc_q;
            end
            default: presc_d = '0;
        endcase
    end

`ifdef TIMER_AUTORELOAD_EN
    always_comb begin
        hold_d = '0;
        if ((state_q == S_EXPIRED) && (state_d == S_EXPIRED)) begin
            hold_d = hold_q + 1'b1;
        end
    end
`endif

    always_comb begin
        reconfig = (state_q == S_LOAD);
        running  = (state_q == S_RUN);
        expired  = (state_q == S_EXPIRED);
        decLSD   = (state_q == S_RUN) && at_term && !timeUp;
    end

endmodule
